// File: rtl/mfp_rojobot_upd_handshake_pkg.sv
// Shared types for the Rojobot update handshake: FSM state encodings used by the
// handshake stage and visible to the IO block.
package mfp_rojobot_upd_handshake_pkg;

  typedef enum logic [1:0] {
    RBH_IDLE = 2'd0,
    RBH_PEND = 2'd1,
    RBH_ACKW = 2'd2
  } rbh_state_e;

  localparam int RBH_SYNC_MIN = 2;
  localparam int RBH_SYNC_MAX = 4;

endpackage

// File: rtl/mfp_sync_ff.sv
// Generic multi-flop synchronizer for asynchronous inputs; all stages reset to 0.
module mfp_sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_r;

  // shift chain, oldest sample in the top stage
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      stage_r <= '0;
    end else begin
      stage_r <= {stage_r[STAGES-2:0], d};
    end
  end

  assign q = stage_r[STAGES-1];

endmodule

// File: rtl/mfp_rojobot_upd_handshake.sv
// Rojobot update handshake: synchronizes upd_sysregs, snapshots bot info, holds the
// update flag until firmware acks, and counts updates overwritten before an ack.
module mfp_rojobot_upd_handshake
  import mfp_rojobot_upd_handshake_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MISS_W      = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              BOT_UPD_RAW,
  input  logic [31:0]       BOT_INFO_RAW,
  input  logic              INT_ACK,
  input  logic              CLR_MISS,
  output logic [31:0]       BOT_INFO_SNAP,
  output logic              BOT_UPDATE_SYNC,
  output logic [MISS_W-1:0] MISS_CNT,
  output logic              OVERRUN
);

  localparam int                SET_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [SET_W-1:0]  SETTLE_N = SET_W'(SYNC_STAGES);
  localparam logic [MISS_W-1:0] MISS_MAX = {MISS_W{1'b1}};
  localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);

  logic              upd_sync_s;
  logic              upd_sync_d_r;
  logic              ack_d_r;
  logic              arm_r;
  logic [SET_W-1:0]  settle_r;
  logic              upd_edge_s;
  logic              ack_edge_s;
  logic              miss_inc_s;
  logic [MISS_W-1:0] miss_nxt_s;
  logic              pend_r;
  rbh_state_e        state_r;
  logic [31:0]       snap_r;
  logic              flag_r;
  logic [MISS_W-1:0] miss_r;
  logic              ovr_r;

  mfp_sync_ff #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_upd_sync (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .d       (BOT_UPD_RAW),
    .q       (upd_sync_s)
  );

  // Edge history plus arming: the chain's reset zeros look like a low level, so an
  // update held through reset must be seen low after the chain flushes before it counts.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      upd_sync_d_r <= 1'b0;
      ack_d_r      <= 1'b0;
      arm_r        <= 1'b0;
      settle_r     <= '0;
    end else begin
      upd_sync_d_r <= upd_sync_s;
      ack_d_r      <= INT_ACK;
      if (settle_r != SETTLE_N) begin
        settle_r <= settle_r + SET_W'(1);
        arm_r    <= arm_r;
      end else begin
        settle_r <= settle_r;
        arm_r    <= arm_r | ~upd_sync_s;
      end
    end
  end

  assign upd_edge_s = upd_sync_s & ~upd_sync_d_r & arm_r;
  assign ack_edge_s = INT_ACK & ~ack_d_r;
  assign miss_inc_s = (state_r == RBH_PEND) & upd_edge_s & ~ack_edge_s;
  assign miss_nxt_s = miss_r + MISS_ONE;

  // Handshake FSM; flag_r is the registered decode of the next state
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= RBH_IDLE;
      flag_r  <= 1'b0;
      pend_r  <= 1'b0;
    end else begin
      case (state_r)
        RBH_IDLE: begin
          pend_r <= 1'b0;
          if (upd_edge_s) begin
            state_r <= RBH_PEND;
            flag_r  <= 1'b1;
          end else begin
            state_r <= RBH_IDLE;
            flag_r  <= 1'b0;
          end
        end
        RBH_PEND: begin
          if (ack_edge_s) begin
            state_r <= RBH_ACKW;
            flag_r  <= 1'b0;
            pend_r  <= upd_edge_s;
          end else begin
            state_r <= RBH_PEND;
            flag_r  <= 1'b1;
            pend_r  <= 1'b0;
          end
        end
        RBH_ACKW: begin
          if (!INT_ACK) begin
            pend_r <= 1'b0;
            if (pend_r || upd_edge_s) begin
              state_r <= RBH_PEND;
              flag_r  <= 1'b1;
            end else begin
              state_r <= RBH_IDLE;
              flag_r  <= 1'b0;
            end
          end else begin
            state_r <= RBH_ACKW;
            flag_r  <= 1'b0;
            pend_r  <= pend_r | upd_edge_s;
          end
        end
        default: begin
          state_r <= RBH_IDLE;
          flag_r  <= 1'b0;
          pend_r  <= 1'b0;
        end
      endcase
    end
  end

  // Snapshot moves only on an accepted update edge, in every state
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      snap_r <= 32'h0000_0000;
    end else if (upd_edge_s) begin
      snap_r <= BOT_INFO_RAW;
    end else begin
      snap_r <= snap_r;
    end
  end

  // Saturating miss counter; a clear coinciding with a miss leaves one miss recorded
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      miss_r <= '0;
      ovr_r  <= 1'b0;
    end else if (CLR_MISS) begin
      miss_r <= miss_inc_s ? MISS_ONE : '0;
      ovr_r  <= miss_inc_s && (MISS_ONE == MISS_MAX);
    end else if (miss_inc_s && (miss_r != MISS_MAX)) begin
      miss_r <= miss_nxt_s;
      ovr_r  <= ovr_r | (miss_nxt_s == MISS_MAX);
    end else begin
      miss_r <= miss_r;
      ovr_r  <= ovr_r;
    end
  end

  assign BOT_INFO_SNAP   = snap_r;
  assign BOT_UPDATE_SYNC = flag_r;
  assign MISS_CNT        = miss_r;
  assign OVERRUN         = ovr_r;

endmodule
